// File: rtl/fir_out_packer_pkg.sv
// Shared types and constants for the FIR output packer and its streamer glue.
package fir_out_packer_pkg;

    localparam int unsigned FIR_SAMPLE_W = 16;
    localparam int unsigned FIR_LEN_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } packer_state_t;

    typedef struct packed {
        logic                 start;
        logic                 clear;
        logic [FIR_LEN_W-1:0] len;
    } ctrl_packer_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic [FIR_LEN_W-1:0] cnt;
    } flags_packer_t;

endpackage

// File: rtl/fir_out_packer_if.sv
// Sample-in / word-out stream bundle between the FIR engine, packer and sink streamer.
interface fir_out_packer_if
    import fir_out_packer_pkg::*;
#(
    parameter int unsigned SAMPLE_W = FIR_SAMPLE_W,
    parameter int unsigned WORD_W   = 2 * SAMPLE_W
);
    logic [SAMPLE_W-1:0] in_data_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [WORD_W-1:0]   out_data_o;
    logic [WORD_W/8-1:0] out_strb_o;
    logic                out_valid_o;
    logic                out_ready_i;

    // master: the packer itself; slave: the engine/streamer environment around it
    modport master (
        input  in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_strb_o, out_valid_o
    );

    modport slave (
        output in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_strb_o, out_valid_o
    );
endinterface

// File: rtl/fir_out_packer_obuf.sv
// Registered single-entry output word buffer; a loaded word holds until accepted.
module fir_out_packer_obuf #(
    parameter int unsigned WORD_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_load,
    input  logic [WORD_W-1:0]   i_data,
    input  logic [WORD_W/8-1:0] i_strb,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [WORD_W-1:0]   o_data,
    output logic [WORD_W/8-1:0] o_strb
);
    logic                r_valid;
    logic [WORD_W-1:0]   r_data;
    logic [WORD_W/8-1:0] r_strb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_strb  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_strb  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_strb  <= i_strb;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_strb  = r_strb;
endmodule

// File: rtl/fir_out_packer.sv
// Packs FIR output sample pairs into words, flushes an odd tail sample, and reports job completion.
module fir_out_packer
    import fir_out_packer_pkg::*;
#(
    parameter int unsigned SAMPLE_W = FIR_SAMPLE_W,
    parameter int unsigned WORD_W   = 2 * SAMPLE_W,
    parameter int unsigned LEN_W    = FIR_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [LEN_W-1:0] len_i,
    fir_out_packer_if.master s,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] cnt_o
);
    localparam int unsigned STRB_W = WORD_W / 8;

    ctrl_packer_t  w_ctrl;
    flags_packer_t w_flags;
    packer_state_t r_state, w_state_nxt;

    logic [LEN_W-1:0]    r_len, r_cnt;
    logic                r_have_lo;
    logic [SAMPLE_W-1:0] r_lo;

    logic                w_last, w_complete, w_in_ready, w_accept, w_load, w_out_valid;
    logic [WORD_W-1:0]   w_word;
    logic [STRB_W-1:0]   w_strb;

    assign w_ctrl = '{start: start_i, clear: clear_i, len: len_i};

    assign w_last     = (r_cnt == r_len - 1'b1);
    assign w_complete = r_have_lo | w_last;
    // The odd tail sample completes a word too, so it also waits behind a held word.
    assign w_in_ready = (r_state == RUN) && (r_cnt < r_len) &&
                        (!w_complete || !w_out_valid || s.out_ready_i);
    assign w_accept   = s.in_valid_i & w_in_ready;
    assign w_load     = w_accept & w_complete;

    assign w_word = r_have_lo ? {s.in_data_i, r_lo}
                              : {{(WORD_W-SAMPLE_W){1'b0}}, s.in_data_i};
    assign w_strb = r_have_lo ? {STRB_W{1'b1}}
                              : {{(STRB_W-STRB_W/2){1'b0}}, {(STRB_W/2){1'b1}}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flags     = '{busy: (r_state != IDLE), done: (r_state == DONE), cnt: r_cnt};
        case (r_state)
            IDLE:  if (w_ctrl.start) w_state_nxt = (w_ctrl.len == '0) ? DONE : RUN;
            RUN:   if (w_accept && w_last) w_state_nxt = FLUSH;
            FLUSH: if (!w_out_valid || s.out_ready_i) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_ctrl.clear) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_have_lo <= 1'b0;
            r_lo      <= '0;
        end else if (w_ctrl.clear) begin
            r_cnt     <= '0;
            r_have_lo <= 1'b0;
        end else if (r_state == IDLE && w_ctrl.start) begin
            r_len     <= w_ctrl.len;
            r_cnt     <= '0;
            r_have_lo <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_complete) begin
                r_have_lo <= 1'b0;
            end else begin
                r_lo      <= s.in_data_i;
                r_have_lo <= 1'b1;
            end
        end
    end

    fir_out_packer_obuf #(.WORD_W(WORD_W)) u_obuf (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_clear (w_ctrl.clear),
        .i_load  (w_load),
        .i_data  (w_word),
        .i_strb  (w_strb),
        .i_ready (s.out_ready_i),
        .o_valid (w_out_valid),
        .o_data  (s.out_data_o),
        .o_strb  (s.out_strb_o)
    );

    assign s.out_valid_o = w_out_valid;
    assign s.in_ready_o  = w_in_ready;
    assign busy_o        = w_flags.busy;
    assign done_o        = w_flags.done;
    assign cnt_o         = w_flags.cnt;
endmodule
